// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and slave FSM state type shared by the slave and
// master sides of the core.
//   htrans_t : transfer type encoding (IDLE, BUSY, NONSEQ, SEQ)
//   HSIZE_*  : transfer size encodings supported by the SRAM slave
//   HRESP_*  : response encodings
//   state_t  : SRAM slave data-phase FSM states
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

endpackage

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: DEPTH x 32-bit storage with per-byte write enables and an
// asynchronous read port. Contents are never reset.
//   clk   : write clock
//   be    : byte-lane write enables, lane i = wdata[8i+7:8i]
//   addr  : word address shared by the write and read ports
//   wdata : write data
//   rdata : combinational read of the word at addr
module ahb_sram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave in front of a MEM_DEPTH x 32-bit SRAM, with a
// configurable number of data-phase wait states and a two-cycle ERROR response
// for misaligned, oversized or out-of-range transfers.
//   clk, reset  : clock and synchronous active-low reset
//   HSEL        : slave select
//   HADDR       : address-phase byte address
//   HTRANS      : transfer type
//   HWRITE      : 1 = write, 0 = read
//   HSIZE       : byte / halfword / word
//   HWDATA      : data-phase write data
//   HREADY      : bus-level ready
//   HREADYOUT   : slave ready (0 stretches the data phase)
//   HRESP       : OKAY / ERROR
//   HRDATA      : read data, held between read completions
//   fsm_state   : current FSM state, for observation
//
// Handshake: an address phase is taken on a rising edge where HSEL=1, HREADY=1,
// HTRANS is NONSEQ/SEQ and this slave is itself ready (HREADYOUT=1). The data
// phase completes on the first later edge where HREADYOUT=1 and HREADY=1;
// HWDATA is sampled and HRDATA is valid on that edge.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output state_t      fsm_state
);

  localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            dp_q, dp_d;       // a valid data phase is outstanding
  logic [AW+1:0]   addr_q;
  logic            write_q;
  logic [2:0]      size_q;
  logic [31:0]     hrdata_q;

  logic            accept;
  logic            xfer_err;
  logic            complete;
  state_t          acc_state;
  logic [3:0]      acc_cnt;
  logic            acc_dp;
  logic [3:0]      be;
  logic [31:0]     mem_rdata;

  // Byte lanes touched by a transfer; unsupported sizes touch nothing.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << a;
      HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = 4'b1111;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

  assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                     ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign fsm_state = state_q;

  assign accept = HSEL && HREADY && HREADYOUT &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  assign xfer_err = (HSIZE > HSIZE_WORD) ||
                    ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                    ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) ||
                    ({2'b00, HADDR[31:2]} >= 32'(MEM_DEPTH));

  assign complete = dp_q && HREADYOUT;

  // Where the FSM goes when the current cycle ends with HREADY=1 and this
  // slave ready; a new address phase may overlap the completing data phase.
  always_comb begin
    acc_state = ST_IDLE;
    acc_cnt   = 4'd0;
    acc_dp    = 1'b0;
    if (accept) begin
      if (xfer_err) begin
        acc_state = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        acc_state = ST_WAIT;
        acc_cnt   = WAIT_INIT;
        acc_dp    = 1'b1;
      end else begin
        acc_dp    = 1'b1;
      end
    end
  end

  // When HREADYOUT=1 but HREADY=0 another slave owns the bus: hold everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dp_d    = dp_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (HREADY) begin
          state_d = acc_state;
          cnt_d   = acc_cnt;
          dp_d    = acc_dp;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (HREADY) begin
          state_d = acc_state;
          cnt_d   = acc_cnt;
          dp_d    = acc_dp;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        dp_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      dp_q     <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'b000;
      hrdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      if (accept) begin
        addr_q  <= HADDR[AW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
      if (complete && !write_q && HREADY) begin
        hrdata_q <= mem_rdata;
      end
    end
  end

  // Reset gating keeps an abandoned data phase from reaching the array.
  assign be = (complete && write_q && HREADY && reset) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;

  // Read data is driven straight from the array in the completion cycle so a
  // read right after a write to the same word sees the new contents.
  assign HRDATA = (complete && !write_q) ? mem_rdata : hrdata_q;

  ahb_sram_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .be    (be),
    .addr  (addr_q[AW+1:2]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave. Three instances with 0, 2 and 3 wait
// states share every bus input except HSEL, so each test talks to exactly one.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bus signals ----------------
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;

  logic        rdy0, rdy2, rdy3;
  logic        rsp0, rsp2, rsp3;
  logic [31:0] rd0, rd2, rd3;
  state_t      st0, st2, st3;

  ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(rdy0), .HRESP(rsp0), .HRDATA(rd0), .fsm_state(st0));

  ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(rdy2), .HRESP(rsp2), .HRDATA(rd2), .fsm_state(st2));

  ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(rdy3), .HRESP(rsp3), .HRDATA(rd3), .fsm_state(st3));

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy0 : (d == 1) ? rdy2 : rdy3;
  endfunction

  function automatic logic rsp_of(input int d);
    return (d == 0) ? rsp0 : (d == 1) ? rsp2 : rsp3;
  endfunction

  function automatic logic [31:0] rd_of(input int d);
    return (d == 0) ? rd0 : (d == 1) ? rd2 : rd3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    hsel   = 3'b000;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
    haddr  = 32'd0;
    hready = 1'b1;
  endtask

  // One non-pipelined transfer. Returns the final response, the response in
  // the first data-phase cycle and the number of cycles with HREADYOUT=0.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output logic resp,
                      output logic fresp, output int waits);
    hsel    = 3'b000;
    hsel[d] = 1'b1;
    haddr   = a;
    hwrite  = wr;
    hsize   = sz;
    htrans  = HTRANS_NONSEQ;
    hready  = 1'b1;
    cyc();
    bus_idle();
    hwdata = wd;
    waits  = 0;
    @(negedge clk);
    fresp = rsp_of(d);
    while (!rdy_of(d) && waits < 32) begin
      waits++;
      @(negedge clk);
    end
    rd   = rd_of(d);
    resp = rsp_of(d);
    cyc();
  endtask

  task automatic wr_do(input string tag, input int d, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd, input int exp_w);
    logic [31:0] rd;
    logic        rs, fr;
    int          w;
    xfer(d, 1'b1, a, sz, wd, rd, rs, fr, w);
    chk({tag, "_waits"}, 32'(w), 32'(exp_w));
    chk({tag, "_resp"}, {31'd0, rs}, {31'd0, HRESP_OKAY});
  endtask

  task automatic rd_do(input string tag, input int d, input logic [31:0] a,
                       input logic [31:0] exp_v, input int exp_w);
    logic [31:0] rd;
    logic        rs, fr;
    int          w;
    exp_q.push_back(exp_v);
    xfer(d, 1'b0, a, HSIZE_WORD, 32'd0, rd, rs, fr, w);
    chk({tag, "_waits"}, 32'(w), 32'(exp_w));
    chk({tag, "_data"}, rd, exp_q.pop_front());
  endtask

  task automatic err_do(input string tag, input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] rd;
    logic        rs, fr;
    int          w;
    xfer(0, 1'b1, a, sz, 32'hFFFF_FFFF, rd, rs, fr, w);
    chk({tag, "_err1_resp"}, {31'd0, fr}, 32'd1);
    chk({tag, "_waits"}, 32'(w), 32'd1);
    chk({tag, "_err2_resp"}, {31'd0, rs}, 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset  = 1'b0;
    hwdata = 32'd0;
    bus_idle();
    cyc();
    cyc();
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready0", {31'd0, rdy0}, 32'd1);
    chk("rst_resp0", {31'd0, rsp0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_state0", 32'(st0), 32'(ST_IDLE));
    chk("rst_ready3", {31'd0, rdy3}, 32'd1);
    chk("rst_rdata2", rd2, 32'd0);
    cyc();

    // Zero-wait back-to-back write then read of 0x10
    hsel   = 3'b001;
    haddr  = 32'h10;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    htrans = HTRANS_NONSEQ;
    cyc();
    hwdata = 32'hDEAD_BEEF;
    hwrite = 1'b0;
    @(negedge clk);
    chk("b2b_wr_ready", {31'd0, rdy0}, 32'd1);
    cyc();
    bus_idle();
    @(negedge clk);
    chk("b2b_rd_ready", {31'd0, rdy0}, 32'd1);
    chk("b2b_rd_data", rd0, 32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    chk("b2b_rd_hold", rd0, 32'hDEAD_BEEF);
    cyc();

    // Byte and halfword lane writes
    wr_do("w40", 0, 32'h40, HSIZE_WORD, 32'h0000_0000, 0);
    wr_do("b41", 0, 32'h41, HSIZE_BYTE, 32'hAAAA_AAAA, 0);
    rd_do("r40", 0, 32'h40, 32'h0000_AA00, 0);
    wr_do("w44", 0, 32'h44, HSIZE_WORD, 32'h0000_0000, 0);
    wr_do("h46", 0, 32'h46, HSIZE_HALF, 32'h5566_7788, 0);
    rd_do("r44", 0, 32'h44, 32'h5566_0000, 0);
    wr_do("b47", 0, 32'h47, HSIZE_BYTE, 32'h1122_3344, 0);
    rd_do("r44b", 0, 32'h44, 32'h1166_0000, 0);

    // Error transfers leave memory untouched
    wr_do("w00", 0, 32'h00, HSIZE_WORD, 32'h1111_1111, 0);
    err_do("e_mis_word", 32'h02, HSIZE_WORD);
    err_do("e_range", 32'(4 * DEPTH), HSIZE_WORD);
    err_do("e_mis_half", 32'h01, HSIZE_HALF);
    err_do("e_size", 32'h00, 3'b011);
    rd_do("r00", 0, 32'h00, 32'h1111_1111, 0);
    wr_do("w_last", 0, 32'(4 * DEPTH - 4), HSIZE_WORD, 32'h7777_0001, 0);
    rd_do("r_last", 0, 32'(4 * DEPTH - 4), 32'h7777_0001, 0);

    // BUSY then IDLE while selected: OKAY, no wait, no write
    hsel   = 3'b001;
    haddr  = 32'h10;
    hwrite = 1'b1;
    htrans = HTRANS_BUSY;
    cyc();
    hwdata = 32'h0BAD_0BAD;
    htrans = HTRANS_IDLE;
    @(negedge clk);
    chk("busy_ready", {31'd0, rdy0}, 32'd1);
    chk("busy_resp", {31'd0, rsp0}, 32'd0);
    cyc();
    @(negedge clk);
    chk("idle_ready", {31'd0, rdy0}, 32'd1);
    chk("idle_state", 32'(st0), 32'(ST_IDLE));
    cyc();
    bus_idle();

    // Not selected
    haddr  = 32'h10;
    hwrite = 1'b1;
    htrans = HTRANS_NONSEQ;
    cyc();
    bus_idle();
    hwdata = 32'h0BAD_0BAD;
    cyc();

    // HREADY low: address phase ignored
    hsel   = 3'b001;
    haddr  = 32'h10;
    hwrite = 1'b1;
    htrans = HTRANS_NONSEQ;
    hready = 1'b0;
    cyc();
    bus_idle();
    hwdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("hready0_state", 32'(st0), 32'(ST_IDLE));
    cyc();
    rd_do("r10_after", 0, 32'h10, 32'hDEAD_BEEF, 0);

    // Two wait states
    wr_do("w20_ws2", 1, 32'h20, HSIZE_WORD, 32'h1234_5678, 2);
    rd_do("r20_ws2", 1, 32'h20, 32'h1234_5678, 2);
    @(negedge clk);
    chk("ws2_hold", rd2, 32'h1234_5678);
    cyc();

    // Reset in the middle of a three-wait-state write
    wr_do("w08_ws3", 2, 32'h08, HSIZE_WORD, 32'hCAFE_F00D, 3);
    rd_do("r08_ws3", 2, 32'h08, 32'hCAFE_F00D, 3);
    hsel   = 3'b100;
    haddr  = 32'h08;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    htrans = HTRANS_NONSEQ;
    cyc();
    bus_idle();
    hwdata = 32'h0BAD_BEEF;
    @(negedge clk);
    chk("ws3_wait_ready", {31'd0, rdy3}, 32'd0);
    chk("ws3_hold_pre", rd3, 32'hCAFE_F00D);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, rdy3}, 32'd1);
    chk("mid_rst_resp", {31'd0, rsp3}, 32'd0);
    chk("mid_rst_rdata", rd3, 32'd0);
    chk("mid_rst_state", 32'(st3), 32'(ST_IDLE));
    cyc();
    rd_do("r08_post", 2, 32'h08, 32'hCAFE_F00D, 3);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
